float_fixed_accumulator: RTL and testbench



---
 rtl/float_fixed_accumulator_if.sv | 25 ++
 rtl/float_fixed_accumulator.sv | 149 ++++++++++++++
 tb/tb_float_fixed_accumulator.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/float_fixed_accumulator_if.sv
// Stream bundle between the fsize_multiplier product output, the fixed-point accumulator and the sum consumer.
// slave is the accumulator's view; master is the view of the logic around it.
interface float_fixed_accumulator_if #(
  parameter int FLOAT_SIZE = 16,
  parameter int ACC_WIDTH  = 32
);
  logic                  s_axis_tvalid;
  logic [FLOAT_SIZE-1:0] s_axis_tdata;
  logic                  m_axis_result_tvalid;
  logic                  m_axis_result_tready;
  logic [ACC_WIDTH-1:0]  m_axis_result_tdata;
  logic                  overflow_flag;
  logic                  drop_flag;
  logic                  clear_flags;

  modport slave (
    input  s_axis_tvalid, s_axis_tdata, m_axis_result_tready, clear_flags,
    output m_axis_result_tvalid, m_axis_result_tdata, overflow_flag, drop_flag
  );

  modport master (
    output s_axis_tvalid, s_axis_tdata, m_axis_result_tready, clear_flags,
    input  m_axis_result_tvalid, m_axis_result_tdata, overflow_flag, drop_flag
  );
endinterface

// File: rtl/float_fixed_accumulator.sv
// Converts float products to signed fixed point and sums N_TERMS of them into one stream output.
// Optional macro SPARQ_ACC_SATURATE_EN: saturate the accumulator on overflow instead of wrapping.
package SPARQ_PKG;
  localparam int EXP_SIZE   = 5;
  localparam int MANT_SIZE  = 10;
  localparam int FLOAT_SIZE = 1 + EXP_SIZE + MANT_SIZE;
  localparam int BIAS       = 15;
endpackage

module float_fixed_accumulator
  import SPARQ_PKG::*;
#(
  parameter int ACC_WIDTH = 32,
  parameter int FRAC_BITS = 16,
  parameter int N_TERMS   = 16
) (
  input logic                      aclk,
  input logic                      aresetn,
  float_fixed_accumulator_if.slave bus
);
  localparam int SIG_W  = MANT_SIZE + 1;
  localparam int WIDE_W = ACC_WIDTH + SIG_W;
  localparam int CNT_W  = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
  localparam logic [CNT_W-1:0]     LAST_CNT = CNT_W'(N_TERMS - 1);
  localparam logic [ACC_WIDTH-1:0] MAX_POS  = {1'b0, {(ACC_WIDTH-1){1'b1}}};
`ifdef SPARQ_ACC_SATURATE_EN
  localparam logic [ACC_WIDTH-1:0] MAX_NEG  = {1'b1, {(ACC_WIDTH-2){1'b0}}, 1'b1};
`endif

  logic                  in_sign;
  logic [EXP_SIZE-1:0]   in_exp;
  logic [SIG_W-1:0]      in_sig;
  logic [WIDE_W-1:0]     in_wide;
  logic [ACC_WIDTH-1:0]  in_mag;
  logic                  in_clamp;
  logic [ACC_WIDTH:0]    in_term;
  int                    in_shift;

  logic                  s1_valid_q;
  logic [ACC_WIDTH:0]    s1_term_q;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d, acc_base;
  logic [ACC_WIDTH:0]    acc_raw;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  complete, add_ovf, ovf_add, ovf_evt, drop_evt;
`ifdef SPARQ_ACC_SATURATE_EN
  logic                  sat_q, sat_d;
`endif

  logic                  out_valid_q, out_valid_d;
  logic [ACC_WIDTH-1:0]  out_data_q, out_data_d;
  logic                  overflow_q, overflow_d;
  logic                  drop_q, drop_d;

  // Stage 1: float -> fixed. Subnormals use an implicit 0 and exponent 1; right shifts truncate toward zero.
  // NOTE: every variable driven here gets a value before any branch, so no path can infer a latch.
  always_comb begin
    in_sign  = bus.s_axis_tdata[FLOAT_SIZE-1];
    in_exp   = bus.s_axis_tdata[FLOAT_SIZE-2 -: EXP_SIZE];
    in_sig   = {(in_exp != '0), bus.s_axis_tdata[MANT_SIZE-1:0]};
    in_shift = ((in_exp == '0) ? 1 : int'(in_exp)) - BIAS - MANT_SIZE + FRAC_BITS;
    in_wide  = '0;
    in_clamp = (in_exp == '1);
    if (in_shift >= ACC_WIDTH)  in_clamp = in_clamp | (in_sig != '0);
    else if (in_shift >= 0)     in_wide  = WIDE_W'(in_sig) << in_shift;
    else if (-in_shift < SIG_W) in_wide  = WIDE_W'(in_sig >> -in_shift);
    if (in_wide[WIDE_W-1:ACC_WIDTH-1] != '0) in_clamp = 1'b1;
    in_mag  = in_clamp ? MAX_POS : in_wide[ACC_WIDTH-1:0];
    in_term = in_sign ? -{1'b0, in_mag} : {1'b0, in_mag};
  end

  // Stage 2: a group restarts from zero, so a partial sum never leaks into the next group.
  always_comb begin
    acc_base = (count_q == '0) ? '0 : acc_q;
    acc_raw  = {acc_base[ACC_WIDTH-1], acc_base} + s1_term_q;
    add_ovf  = acc_raw[ACC_WIDTH] != acc_raw[ACC_WIDTH-1];
    acc_d    = acc_q;
    count_d  = count_q;
    complete = 1'b0;
    ovf_add  = 1'b0;
`ifdef SPARQ_ACC_SATURATE_EN
    sat_d    = sat_q;
`endif
    if (s1_valid_q) begin
      complete = (count_q == LAST_CNT);
      count_d  = complete ? '0 : count_q + 1'b1;
`ifdef SPARQ_ACC_SATURATE_EN
      // Once clamped, the group keeps the clamp value until it completes.
      if (!sat_q || count_q == '0) begin
        ovf_add = add_ovf;
        sat_d   = add_ovf;
        acc_d   = add_ovf ? (acc_raw[ACC_WIDTH] ? MAX_NEG : MAX_POS) : acc_raw[ACC_WIDTH-1:0];
      end
`else
      ovf_add = add_ovf;
      acc_d   = acc_raw[ACC_WIDTH-1:0];
`endif
    end
  end

  // A full holding register that is not being drained loses the newly completed sum.
  always_comb begin
    drop_evt    = complete && out_valid_q && !bus.m_axis_result_tready;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (complete && !drop_evt) begin
      out_valid_d = 1'b1;
      out_data_d  = acc_d;
    end else if (out_valid_q && bus.m_axis_result_tready) begin
      out_valid_d = 1'b0;
    end
    ovf_evt    = (bus.s_axis_tvalid && in_clamp) || ovf_add;
    overflow_d = (overflow_q && !bus.clear_flags) || ovf_evt;
    drop_d     = (drop_q && !bus.clear_flags) || drop_evt;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s1_valid_q  <= 1'b0;
      s1_term_q   <= '0;
      acc_q       <= '0;
      count_q     <= '0;
`ifdef SPARQ_ACC_SATURATE_EN
      sat_q       <= 1'b0;
`endif
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      overflow_q  <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      s1_valid_q <= bus.s_axis_tvalid;
      if (bus.s_axis_tvalid) s1_term_q <= in_term;
      acc_q       <= acc_d;
      count_q     <= count_d;
`ifdef SPARQ_ACC_SATURATE_EN
      sat_q       <= sat_d;
`endif
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      overflow_q  <= overflow_d;
      drop_q      <= drop_d;
    end
  end

  assign bus.m_axis_result_tvalid = out_valid_q;
  assign bus.m_axis_result_tdata  = out_data_q;
  assign bus.overflow_flag        = overflow_q;
  assign bus.drop_flag            = drop_q;
endmodule

// File: tb/tb_float_fixed_accumulator.sv
// Bench for float_fixed_accumulator: an N_TERMS=4 and an N_TERMS=1 instance on shared stimulus,
// compared every cycle against a value-level reference model, plus directed scenario checks.
module tb_float_fixed_accumulator;
  localparam longint MAXP = 64'sd2147483647;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        in_clear;

  int    n_checks = 0;
  int    n_errors = 0;
  string cur_tag  = "init";

  always #5 aclk = ~aclk;

  float_fixed_accumulator_if #(.FLOAT_SIZE(16), .ACC_WIDTH(32)) bus4 ();
  float_fixed_accumulator_if #(.FLOAT_SIZE(16), .ACC_WIDTH(32)) bus1 ();

  assign bus4.s_axis_tvalid        = in_valid;
  assign bus4.s_axis_tdata         = in_data;
  assign bus4.m_axis_result_tready = in_ready;
  assign bus4.clear_flags          = in_clear;
  assign bus1.s_axis_tvalid        = in_valid;
  assign bus1.s_axis_tdata         = in_data;
  assign bus1.m_axis_result_tready = in_ready;
  assign bus1.clear_flags          = in_clear;

  float_fixed_accumulator #(.ACC_WIDTH(32), .FRAC_BITS(16), .N_TERMS(4)) dut4 (
    .aclk(aclk), .aresetn(aresetn), .bus(bus4.slave));
  float_fixed_accumulator #(.ACC_WIDTH(32), .FRAC_BITS(16), .N_TERMS(1)) dut1 (
    .aclk(aclk), .aresetn(aresetn), .bus(bus1.slave));

  // Reference model state, index 0 -> N_TERMS=4, index 1 -> N_TERMS=1.
  int     nterms [2] = '{4, 1};
  bit     m_pv   [2];
  longint m_pt   [2];
  longint m_acc  [2];
  int     m_cnt  [2];
  bit     m_sat  [2];
  bit     m_ov   [2];
  longint m_od   [2];
  bit     m_of   [2];
  bit     m_df   [2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic real pow2(input int k);
    real r = 1.0;
    if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
    else        for (int i = 0; i < -k; i++) r = r / 2.0;
    return r;
  endfunction

  // Real value of the fp16 word scaled by 2^16, truncated toward zero; clamps if it needs 32+ bits.
  function automatic longint conv(input logic [15:0] f, output bit clamp);
    int     ex;
    int     m;
    real    v;
    longint mag;
    ex    = int'(f[14:10]);
    m     = int'(f[9:0]);
    clamp = 1'b0;
    if (ex == 31) begin
      clamp = 1'b1;
      mag   = MAXP;
    end else begin
      if (ex == 0) v = real'(m) * pow2(-24);
      else         v = (1.0 + real'(m) / 1024.0) * pow2(ex - 15);
      v = v * 65536.0;
      if (v >= 2147483648.0) begin
        clamp = 1'b1;
        mag   = MAXP;
      end else begin
        mag = longint'($rtoi(v));
      end
    end
    return f[15] ? -mag : mag;
  endfunction

  function automatic longint wrap32(input longint v);
    logic [31:0] lo;
    lo = v[31:0];
    return longint'($signed(lo));
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_pv[d] = 0; m_pt[d] = 0; m_acc[d] = 0; m_cnt[d] = 0; m_sat[d] = 0;
      m_ov[d] = 0; m_od[d] = 0; m_of[d] = 0; m_df[d] = 0;
    end
  endtask

  // Advance model d by one clock using the input values present before the edge.
  task automatic model_edge(input int d);
    bit     comp   = 0;
    bit     ovf_ev = 0;
    bit     dr     = 0;
    bit     clamp;
    longint s      = 0;
    if (m_pv[d]) begin
      s = ((m_cnt[d] == 0) ? 0 : m_acc[d]) + m_pt[d];
`ifdef SPARQ_ACC_SATURATE_EN
      if (m_sat[d] && m_cnt[d] != 0) begin
        s = m_acc[d];
      end else begin
        m_sat[d] = 0;
        if (s > MAXP)           begin s = MAXP;  m_sat[d] = 1; ovf_ev = 1; end
        else if (s < -MAXP - 1) begin s = -MAXP; m_sat[d] = 1; ovf_ev = 1; end
      end
`else
      if (s > MAXP || s < -MAXP - 1) ovf_ev = 1;
      s = wrap32(s);
`endif
      m_acc[d] = s;
      comp     = (m_cnt[d] == nterms[d] - 1);
      m_cnt[d] = comp ? 0 : m_cnt[d] + 1;
    end
    if (comp) begin
      if (!m_ov[d] || in_ready) begin m_ov[d] = 1; m_od[d] = s; end
      else dr = 1;
    end else if (m_ov[d] && in_ready) begin
      m_ov[d] = 0;
    end
    if (in_clear) begin m_of[d] = 0; m_df[d] = 0; end
    if (ovf_ev) m_of[d] = 1;
    if (dr)     m_df[d] = 1;
    m_pv[d] = in_valid;
    if (in_valid) begin
      m_pt[d] = conv(in_data, clamp);
      if (clamp) m_of[d] = 1;
    end
  endtask

  task automatic compare_dut(input int d);
    logic        v, of, df;
    logic [31:0] dt;
    if (d == 0) begin
      v = bus4.m_axis_result_tvalid; dt = bus4.m_axis_result_tdata;
      of = bus4.overflow_flag; df = bus4.drop_flag;
    end else begin
      v = bus1.m_axis_result_tvalid; dt = bus1.m_axis_result_tdata;
      of = bus1.overflow_flag; df = bus1.drop_flag;
    end
    check($sformatf("%s/n%0d tvalid", cur_tag, nterms[d]), 64'(v), 64'(m_ov[d]));
    if (m_ov[d]) check($sformatf("%s/n%0d tdata", cur_tag, nterms[d]), 64'(dt), 64'(m_od[d][31:0]));
    check($sformatf("%s/n%0d overflow", cur_tag, nterms[d]), 64'(of), 64'(m_of[d]));
    check($sformatf("%s/n%0d drop", cur_tag, nterms[d]), 64'(df), 64'(m_df[d]));
  endtask

  task automatic step();
    @(posedge aclk);
    if (!aresetn) model_reset();
    else for (int d = 0; d < 2; d++) model_edge(d);
    #1;
    for (int d = 0; d < 2; d++) compare_dut(d);
  endtask

  task automatic send(input logic [15:0] f);
    in_valid = 1'b1;
    in_data  = f;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b0;
      in_data  = 16'($urandom);
      step();
    end
  endtask

  task automatic check_out4(input string tag, input logic v, input logic [31:0] dt);
    check({tag, " tvalid"}, 64'(bus4.m_axis_result_tvalid), 64'(v));
    check({tag, " tdata"}, 64'(bus4.m_axis_result_tdata), 64'(dt));
  endtask

  function automatic logic [15:0] rand_fp();
    int         r = $urandom_range(0, 99);
    logic [4:0] e;
    if (r < 80)      e = 5'($urandom_range(0, 20));
    else if (r < 95) e = 5'($urandom_range(21, 30));
    else             e = 5'd31;
    return {1'($urandom_range(0, 1)), e, 10'($urandom_range(0, 1023))};
  endfunction

  initial begin
    logic [31:0] ovf_sum;
    in_valid = 1'b0; in_data = '0; in_ready = 1'b1; in_clear = 1'b0; aresetn = 1'b0;
    model_reset();

    cur_tag = "reset";
    idle(2);
    check_out4("reset", 1'b0, 32'h0);
    check("reset overflow", 64'(bus4.overflow_flag), 64'h0);
    check("reset drop", 64'(bus4.drop_flag), 64'h0);
    aresetn = 1'b1;

    cur_tag = "basic";
    repeat (4) send(16'h3C00);
    idle(1);
    check_out4("basic 2 cycles after last term", 1'b1, 32'h0004_0000);
    idle(2);

    cur_tag = "mixed";
    send(16'h4000); idle(1); send(16'hC000); send(16'h3800); idle(1); send(16'h0001);
    idle(1);
    check_out4("mixed with gaps", 1'b1, 32'h0000_8000);
    idle(2);

    cur_tag = "backpressure";
    in_ready = 1'b0;
    repeat (4) send(16'h3C00);
    repeat (4) send(16'h3800);
    idle(2);
    check_out4("stall holds first sum", 1'b1, 32'h0004_0000);
    check("stall drop_flag", 64'(bus4.drop_flag), 64'h1);
    in_ready = 1'b1;
    idle(1);
    check("after transfer tvalid", 64'(bus4.m_axis_result_tvalid), 64'h0);
    in_clear = 1'b1;
    idle(1);
    in_clear = 1'b0;
    check("clear drop_flag", 64'(bus4.drop_flag), 64'h0);

    cur_tag = "overflow";
    repeat (4) send(16'h7BFF);
    idle(1);
    // 65504 needs 32 magnitude bits, so each term already clamps to 0x7FFFFFFF before summing.
`ifdef SPARQ_ACC_SATURATE_EN
    ovf_sum = 32'h7FFF_FFFF;
`else
    ovf_sum = 32'hFFFF_FFFC;
`endif
    check_out4("overflow sum", 1'b1, ovf_sum);
    check("overflow_flag", 64'(bus4.overflow_flag), 64'h1);
    in_clear = 1'b1;
    send(16'hFC00);
    in_clear = 1'b0;
    check("clear vs inf event", 64'(bus4.overflow_flag), 64'h1);

    cur_tag = "reset_mid";
    idle(1);
    send(16'h3C00); send(16'h3C00);
    aresetn = 1'b0;
    model_reset();
    #1;
    check_out4("in reset", 1'b0, 32'h0);
    check("in reset overflow", 64'(bus4.overflow_flag), 64'h0);
    check("in reset drop", 64'(bus4.drop_flag), 64'h0);
    idle(1);
    aresetn = 1'b1;
    repeat (4) send(16'h3C00);
    idle(1);
    check_out4("after mid-group reset", 1'b1, 32'h0004_0000);
    idle(2);

    cur_tag = "nterms1";
    in_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      send(16'h3C00);
      if (i >= 2) begin
        check("n1 stream tvalid", 64'(bus1.m_axis_result_tvalid), 64'h1);
        check("n1 stream tdata", 64'(bus1.m_axis_result_tdata), 64'h0001_0000);
      end
    end
    idle(2);

    cur_tag = "random";
    for (int i = 0; i < 600; i++) begin
      in_valid = ($urandom_range(0, 9) < 7);
      in_data  = rand_fp();
      in_ready = ($urandom_range(0, 3) != 0);
      in_clear = ($urandom_range(0, 32) == 0);
      step();
    end
    in_clear = 1'b0;
    in_ready = 1'b1;
    idle(4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
